i2c_slave_regs: RTL
===================

Name: i2c_slave_regs

Overview:
- I2C target (slave) that answers the team's I2C master on the same two-wire bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit device address and exposes a byte-wide register port to user logic: register pointer write, multi-byte write, and current/combined-format multi-byte read with pointer auto-increment.
- Drives SDA (and SCL when stretching is compiled in) open-drain via active-high pull-low enables.

Parameters:
- DEV_ADDR, 7'h4B, 7-bit address this target responds to.
- PTR_RESET, 8'h00, register pointer value after reset.

Ports:
- clk  in  1  system clock, at least 20x SCL rate.
- reset  in  1  synchronous, active-low reset.
- scl_in  in  1  raw SCL pad input (asynchronous).
- sda_in  in  1  raw SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- reg_addr  out  8  current register pointer.
- reg_wdata  out  8  received write byte.
- reg_we  out  1  one-clk write strobe; reg_addr/reg_wdata valid in the same cycle.
- reg_re  out  1  one-clk strobe; reg_rdata is captured on the following clk.
- reg_rdata  in  8  read data for reg_addr.
- busy  out  1  high from address match until STOP or non-matching address.
- nack_seen  out  1  one-clk pulse when the master NACKs a read byte.

Behaviour:
- Input conditioning: two-flop synchronizer on scl_in and sda_in, plus one history flop each. Edges and START/STOP are decoded from synchronized values, so latency from pad to detection is 3 clk.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Data bits are sampled on SCL rise. sda_oe changes only on the clk after SCL fall is detected.
- Reset values: sda_oe=0, reg_we=0, reg_re=0, busy=0, nack_seen=0, reg_wdata=0, reg_addr=PTR_RESET, bit counter=0, state IDLE.
- States and transitions:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits MSB first. If [7:1]==DEV_ADDR -> ADDR_ACK and busy=1. Otherwise -> IDLE with SDA untouched.
  - ADDR_ACK: sda_oe=1 for the 9th clock, released after its falling edge.
    - R/W=0 -> PTR.
    - R/W=1 -> RDATA; pulse reg_re at the ACK SCL rise and load the shift register on the next clk.
  - PTR: shift 8 bits -> PTR_ACK. reg_addr <= byte at the 8th rise. ACK, then -> WDATA.
  - WDATA: shift 8 bits. At the 8th rise: reg_wdata <= byte, reg_we pulse, then -> WDATA_ACK. ACK, then -> WDATA. reg_addr increments on the clk after reg_we.
  - RDATA: drive bit (sda_oe = ~bit) after each SCL fall, MSB first. After 8 bits release SDA -> RDATA_MACK.
  - RDATA_MACK: sample at SCL rise.
    - SDA=0: reg_addr+1, reg_re pulse, reload -> RDATA.
    - SDA=1: nack_seen pulse -> WAIT_STOP; SDA stays released.
  - WAIT_STOP: idle until START or STOP.
- Repeated START in any state: sda_oe=0, bit counter cleared -> ADDR. busy stays 1 only if the new address matches.
- STOP in any state: sda_oe=0, busy=0 -> IDLE. If STOP arrives mid-byte in WDATA, the partial byte is discarded with no reg_we.
- reg_addr is 8-bit and wraps 8'hFF -> 8'h00 on increment.
- reg_we and reg_re are never asserted in the same cycle.
- reset low mid-transfer releases SDA in the next cycle; all reset values apply.
- A START is never detected while sda_oe=1 (own drive), because SDA is changed only while SCL is low.

Optional Feature:
- Macro I2C_SLAVE_STRETCH_EN.
- Defined: adds input reg_rdy (1) and output scl_oe (1).
  - After the ACK falling edge that precedes a read byte, and after each reg_we, scl_oe=1 holds SCL low.
  - Hold continues until reg_rdy=1 is sampled; scl_oe is released on the next clk.
  - reg_rdata is captured on that release clk.
  - scl_oe resets to 0 and is forced to 0 on STOP/START.
- Undefined: ports absent, no stretching. reg_rdata must be valid one clk after reg_re.

Test Plan:
- Write with pointer: START, 0x96 (addr 0x4B W), 0x10, 0xA5, 0x5A, STOP -> three ACKs; reg_we at (0x10,0xA5) then (0x11,0x5A); busy falls 3 clk after STOP.
- Combined read: START 0x96, 0x20, Sr, 0x97, master ACK then NACK, STOP, with user returning reg_rdata=addr^8'hFF.
  - Bytes read are 0xDF, 0xDE.
  - nack_seen pulses once.
  - reg_addr=0x21 at the end.
- Address mismatch: START, 0x90, 0x01, STOP -> sda_oe never asserts; no reg_we; busy stays 0.
- Wrap: pointer 0xFF, write 2 bytes -> reg_we at 0xFF then 0x00.
- Abort: STOP after 4 data bits of WDATA -> no reg_we. Separately, reset low during RDATA with sda_oe=1 -> sda_oe=0 next clk, state IDLE, reg_addr=PTR_RESET.
- With I2C_SLAVE_STRETCH_EN: reg_rdy held low 50 clk before a read byte -> SCL held low 50+1 clk; byte content is correct after release.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// I2C target exposing a byte-wide register port with an auto-incrementing pointer.
// Optional SCL clock stretching is compiled in with `define I2C_SLAVE_STRETCH_EN.
module i2c_slave_regs #(
   parameter logic [6:0] DEV_ADDR  = 7'h4B,
   parameter logic [7:0] PTR_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
`ifdef I2C_SLAVE_STRETCH_EN
   input  logic       reg_rdy,
   output logic       scl_oe,
`endif
   output logic       busy,
   output logic       nack_seen
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, WAIT_STOP
   } state_t;

   state_t     state;
   logic [2:0] scl_pipe, sda_pipe;
   logic       scl_s, scl_d, sda_s, sda_d;
   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [3:0] bit_cnt;
   logic [7:0] shift;
   logic [7:0] byte_in;
   logic       rw;
`ifdef I2C_SLAVE_STRETCH_EN
   logic       stretch_pend;
`endif

   // Two synchronizer flops plus one history flop; idle bus level is high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         scl_pipe <= 3'b111;
         sda_pipe <= 3'b111;
      end else begin
         scl_pipe <= {scl_pipe[1:0], scl_in};
         sda_pipe <= {sda_pipe[1:0], sda_in};
      end
   end

   assign scl_s     = scl_pipe[1];
   assign scl_d     = scl_pipe[2];
   assign sda_s     = sda_pipe[1];
   assign sda_d     = sda_pipe[2];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
   assign byte_in   = {shift[6:0], sda_s};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         rw        <= 1'b0;
         sda_oe    <= 1'b0;
         reg_addr  <= PTR_RESET;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         busy      <= 1'b0;
         nack_seen <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
         scl_oe       <= 1'b0;
         stretch_pend <= 1'b0;
`endif
      end else begin
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         nack_seen <= 1'b0;
         if (reg_we)
            reg_addr <= reg_addr + 8'd1;
`ifndef I2C_SLAVE_STRETCH_EN
         if (reg_re)
            shift <= reg_rdata;
`endif
         if (stop_det) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe       <= 1'b0;
            stretch_pend <= 1'b0;
`endif
         end else if (start_det) begin
            state   <= ADDR;
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oe       <= 1'b0;
            stretch_pend <= 1'b0;
`endif
         end else begin
`ifdef I2C_SLAVE_STRETCH_EN
            // A stretched read byte loads its data and drives its MSB on the release clk.
            if (scl_oe && reg_rdy) begin
               scl_oe <= 1'b0;
               if (state == RDATA) begin
                  shift   <= {reg_rdata[6:0], 1'b0};
                  sda_oe  <= ~reg_rdata[7];
                  bit_cnt <= 4'd1;
               end
            end
`endif
            case (state)
               IDLE, WAIT_STOP: ;
               ADDR: if (scl_rise) begin
                  shift <= byte_in;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= '0;
                     rw      <= sda_s;
                     if (byte_in[7:1] == DEV_ADDR) begin
                        busy  <= 1'b1;
                        state <= ADDR_ACK;
                     end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end
                  end else
                     bit_cnt <= bit_cnt + 4'd1;
               end
               // ACK is driven on the first SCL fall and released on the second.
               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe)
                        sda_oe <= 1'b1;
                     else begin
                        sda_oe <= 1'b0;
                        state  <= PTR;
                     end
                  end else if (scl_rise && rw) begin
                     reg_re  <= 1'b1;
                     bit_cnt <= '0;
                     state   <= RDATA;
                  end
               end
               PTR: if (scl_rise) begin
                  shift <= byte_in;
                  if (bit_cnt == 4'd7) begin
                     reg_addr <= byte_in;
                     bit_cnt  <= '0;
                     state    <= PTR_ACK;
                  end else
                     bit_cnt <= bit_cnt + 4'd1;
               end
               PTR_ACK, WDATA_ACK: if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe <= 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
                     if (stretch_pend) begin
                        scl_oe       <= 1'b1;
                        stretch_pend <= 1'b0;
                     end
`endif
                  end else begin
                     sda_oe <= 1'b0;
                     state  <= WDATA;
                  end
               end
               WDATA: if (scl_rise) begin
                  shift <= byte_in;
                  if (bit_cnt == 4'd7) begin
                     reg_wdata <= byte_in;
                     reg_we    <= 1'b1;
                     bit_cnt   <= '0;
                     state     <= WDATA_ACK;
`ifdef I2C_SLAVE_STRETCH_EN
                     stretch_pend <= 1'b1;
`endif
                  end else
                     bit_cnt <= bit_cnt + 4'd1;
               end
               RDATA: if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= '0;
                     state   <= RDATA_MACK;
`ifdef I2C_SLAVE_STRETCH_EN
                  end else if (bit_cnt == 4'd0) begin
                     sda_oe <= 1'b0;
                     scl_oe <= 1'b1;
`endif
                  end else begin
                     sda_oe  <= ~shift[7];
                     shift   <= {shift[6:0], 1'b0};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               RDATA_MACK: if (scl_rise) begin
                  if (!sda_s) begin
                     reg_addr <= reg_addr + 8'd1;
                     reg_re   <= 1'b1;
                     state    <= RDATA;
                  end else begin
                     nack_seen <= 1'b1;
                     state     <= WAIT_STOP;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
